// File: rtl/riscv_pkg.sv
// Shared front-end definitions: widths, NOP encoding and the fetch FSM state type.
// Latency: none (types and constants only).
// Backpressure: none.
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int INSTR_W      = 32;

    // addi x0, x0, 0 -- shown on out_instr whenever the buffer has nothing valid
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    // RUN: fetching normally. DRAIN: discarding responses that belong to a
    // redirected-away path before new requests may issue.
    typedef enum logic [0:0] {
        FETCH_RUN   = 1'b0,
        FETCH_DRAIN = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush, used for the instruction buffer and the PC tag queue.
// Latency: a pushed entry is visible at pop_data the cycle after the push.
// Backpressure: a push into a full FIFO is ignored unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Pointer and occupancy tracking; flush empties the queue after any same-cycle pop.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; no reset needed since count gates what is visible.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues in-order word fetches, buffers returned words with their PCs for decode.
// Latency: a response is visible on out_valid the cycle after it returns; requests issue same cycle as credit frees.
// Backpressure: requests stop while buffer occupancy plus outstanding requests reaches DEPTH; out_ready stalls the buffer head.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = INSTR_W + XLEN;

    fetch_state_t     state;
    logic [XLEN-1:0]  fetch_pc;
    logic [CW-1:0]    outstanding;
    logic [CW-1:0]    outstanding_net;
    logic [CW-1:0]    drop_cnt;

    logic [CW-1:0]    buf_count;
    logic             buf_empty;
    logic [BW-1:0]    buf_head;
    logic [CW-1:0]    tag_count;
    logic             tag_empty;
    logic [XLEN-1:0]  tag_head;

    logic [CW:0]      credit_used;
    logic             req_fire;
    logic             rsp_ret;
    logic             rsp_keep;
    logic             out_fire;

    // Every issued request reserves a buffer slot until its word is consumed,
    // so the buffer can never overflow no matter when responses arrive.
    assign credit_used = {1'b0, buf_count} + {1'b0, outstanding};

    // The tag-queue slot check is a backstop: in RUN the tag queue holds exactly
    // one entry per outstanding request, so the credit check already covers it.
    assign imem_req_valid = !rst
                          && (state == FETCH_RUN)
                          && !redirect_valid
                          && (credit_used < (CW + 1)'(DEPTH))
                          && (tag_count < CW'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A returning word retires one outstanding request; it is kept only in RUN
    // and only when no redirect is flushing the path in the same cycle.
    assign rsp_ret         = imem_rsp_valid && (outstanding != '0);
    assign rsp_keep        = rsp_ret && (state == FETCH_RUN) && !redirect_valid && !tag_empty && !rst;
    assign outstanding_net = outstanding - CW'(rsp_ret);

    assign out_valid = !rst && !buf_empty;
    assign out_fire  = out_valid && out_ready;
    assign out_instr = out_valid ? buf_head[BW-1 -: INSTR_W] : NOP_INSTR;
    assign out_pc    = out_valid ? buf_head[XLEN-1:0] : '0;

    // Fetch FSM: PC sequencing, outstanding/drop accounting and RUN/DRAIN control.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH_RUN;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_net + CW'(req_fire);
            if (redirect_valid) begin
                // Clear the two low bits to force word alignment; everything still
                // in flight (minus a word landing right now) belongs to the old path.
                fetch_pc <= redirect_pc & ~XLEN'(3);
                drop_cnt <= outstanding_net;
                state    <= (outstanding_net != '0) ? FETCH_DRAIN : FETCH_RUN;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (state == FETCH_DRAIN) begin
                    if (rsp_ret) begin
                        drop_cnt <= drop_cnt - CW'(1);
                    end
                    if ((drop_cnt == '0) || (rsp_ret && (drop_cnt == CW'(1)))) begin
                        state <= FETCH_RUN;
                    end
                end
            end
        end
    end

    // PC of each outstanding request, popped in order as its word returns.
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_q (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (rsp_keep),
        .pop_data  (tag_head),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    // Instruction buffer: {instruction, pc} per entry, head drives decode.
    sync_fifo #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data ({imem_rsp_data, tag_head}),
        .pop       (out_fire),
        .pop_data  (buf_head),
        .empty     (buf_empty),
        .count     (buf_count)
    );

    // A kept word must always find room in the buffer.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(rsp_keep && (buf_count == CW'(DEPTH)) && !out_fire));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model, scoreboard of expected decode words.
// Latency: memory responds 1..4 cycles after acceptance, in order.
// Backpressure: randomised memory ready and decode ready, plus redirects and resets.
module tb_fetch_unit;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    fetch_unit #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mem_q[$];
    int    lat_min = 1;
    int    lat_max = 1;
    int    rdy_pct = 100;

    always @(negedge clk) begin
        if (!rst && imem_req_valid && imem_req_ready)
            mem_q.push_back('{imem_req_addr, cyc + $urandom_range(lat_max, lat_min)});
    end

    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                mem_q.delete();
                imem_rsp_valid = 1'b0;
                imem_req_ready = 1'b0;
            end else begin
                imem_req_ready = ($urandom_range(99) < rdy_pct);
                if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(mem_q[0].addr);
                    void'(mem_q.pop_front());
                end else begin
                    imem_rsp_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    // A fetched word reaches decode iff its request was accepted after the most
    // recent redirect/reset and it did not return in a redirect cycle. Decode
    // then sees those words in request order.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    typedef struct {
        logic [31:0] addr;
        int          ep;
    } tag_t;

    exp_t        exp_q[$];
    tag_t        tag_q[$];
    int          epoch = 0;
    logic [31:0] model_pc = RESET_PC;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    logic [31:0] last_acc_addr = '0;
    logic [31:0] last_pop_pc = '0;
    bit          saw_wrap = 1'b0;
    int          stale;
    bit          exp_req;
    exp_t        e;
    tag_t        t;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_req_valid", imem_req_valid, 1'b0);
            check("rst_out_valid", out_valid, 1'b0);
            check("rst_out_instr", out_instr, 32'h0000_0013);
            check("rst_out_pc", out_pc, 32'h0);
            exp_q.delete();
            tag_q.delete();
            epoch    = 0;
            model_pc = RESET_PC;
        end else begin
            stale = 0;
            foreach (tag_q[i]) if (tag_q[i].ep != epoch) stale++;
            exp_req = !redirect_valid && (stale == 0) && (exp_q.size() + tag_q.size() < DEPTH);
            check("req_valid", imem_req_valid, exp_req);
            check("out_valid", out_valid, exp_q.size() != 0);

            if (out_valid && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_pc", out_pc, e.pc);
                check("out_instr", out_instr, e.instr);
                pop_cnt++;
                last_pop_pc = out_pc;
            end

            if (imem_rsp_valid) begin
                if (tag_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stray_rsp: response with no request in flight (cycle %0d)", cyc);
                end else begin
                    t = tag_q.pop_front();
                    if (!redirect_valid && t.ep == epoch)
                        exp_q.push_back('{t.addr, mem_word(t.addr)});
                end
            end

            if (redirect_valid) begin
                exp_q.delete();
                epoch++;
                model_pc = redirect_pc & ~32'h3;
            end

            if (imem_req_valid) begin
                check("req_addr", imem_req_addr, model_pc);
                if (imem_req_ready) begin
                    tag_q.push_back('{model_pc, epoch});
                    acc_cnt++;
                    if (imem_req_addr == 32'h0 && last_acc_addr == 32'hFFFF_FFFC) saw_wrap = 1'b1;
                    last_acc_addr = imem_req_addr;
                    model_pc      = model_pc + 32'd4;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_accept(input int base, input string name);
        int n = 0;
        while (acc_cnt <= base && n < 50) begin
            tick();
            n++;
        end
        check(name, acc_cnt > base, 1'b1);
    endtask

    task automatic wait_pop(input int base, input string name);
        int n = 0;
        while (pop_cnt <= base && n < 50) begin
            tick();
            n++;
        end
        check(name, pop_cnt > base, 1'b1);
    endtask

    initial begin
        int a0;
        int p0;
        int n;

        // Reset, then a steady stream: 1-cycle memory, always ready.
        ticks(3);
        rst = 1'b0;
        p0  = pop_cnt;
        wait_pop(p0, "first_pop_seen");
        check("first_out_pc", last_pop_pc, 32'h100);
        ticks(4);
        p0 = pop_cnt;
        ticks(16);
        check("stream_rate", pop_cnt - p0, 16);

        // Decode stalled: exactly DEPTH requests, then fetching resumes at 0x110.
        rst       = 1'b1;
        out_ready = 1'b0;
        ticks(2);
        a0  = acc_cnt;
        rst = 1'b0;
        ticks(12);
        check("stall_accepts", acc_cnt - a0, DEPTH);
        check("stall_req_low", imem_req_valid, 1'b0);
        check("stall_out_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        wait_accept(a0 + DEPTH, "resume_seen");
        check("resume_addr", last_acc_addr, 32'h110);

        // Reset with requests in flight and words buffered.
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        lat_min   = 3;
        lat_max   = 3;
        out_ready = 1'b0;
        ticks(4);
        check("midrst_setup_out_valid", out_valid, 1'b1);
        check("midrst_setup_inflight", tag_q.size(), 3);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_req_valid", imem_req_valid, 1'b0);
        tick();
        check("midrst_out_valid_next", out_valid, 1'b0);
        rst = 1'b0;
        #1;
        check("postrst_req_valid", imem_req_valid, 1'b1);
        check("postrst_req_addr", imem_req_addr, RESET_PC);

        // Redirect to 0x2002 with two requests outstanding (3-cycle memory).
        out_ready = 1'b1;
        n = 0;
        while (tag_q.size() != 2 && n < 20) begin
            tick();
            n++;
        end
        check("drain_setup_inflight", tag_q.size(), 2);
        a0             = acc_cnt;
        p0             = pop_cnt;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        tick();
        redirect_valid = 1'b0;
        wait_accept(a0, "drain_resume_seen");
        check("drain_next_addr", last_acc_addr, 32'h2000);
        wait_pop(p0, "drain_pop_seen");
        check("drain_first_out_pc", last_pop_pc, 32'h2000);

        // Address wrap at the top of the address space.
        lat_min        = 1;
        lat_max        = 1;
        saw_wrap       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF6;
        tick();
        redirect_valid = 1'b0;
        ticks(15);
        check("pc_wrap", saw_wrap, 1'b1);

        // Redirect landing with a response and a decode pop in the same cycle.
        ticks(10);
        #2;
        check("coincide_setup", {out_valid, imem_rsp_valid, out_ready}, 3'b111);
        p0             = pop_cnt;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        tick();
        redirect_valid = 1'b0;
        #1;
        check("coincide_pop_once", pop_cnt - p0, 1);
        check("coincide_flushed", out_valid, 1'b0);
        check("coincide_req_valid", imem_req_valid, 1'b1);
        check("coincide_req_addr", imem_req_addr, 32'h3000);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            if (i % 250 == 0) begin
                lat_min = 1;
                lat_max = $urandom_range(4, 1);
                rdy_pct = $urandom_range(100, 40);
            end
            out_ready      = ($urandom_range(99) < 70);
            redirect_valid = ($urandom_range(99) < 4);
            redirect_pc    = $urandom;
            rst            = ($urandom_range(999) < 2);
            tick();
        end

        // Quiesce: everything expected must have reached decode.
        rst            = 1'b0;
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        rdy_pct        = 0;
        ticks(40);
        check("final_exp_empty", exp_q.size(), 0);
        check("final_inflight_empty", tag_q.size(), 0);
        check("final_out_valid", out_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
